// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor: the per-sprite
// attribute record and the coordinate width used by every hit test.
package sprite_pkg;

    localparam int SCREEN_W   = 640;
    localparam int COORD_W    = 11;
    localparam int MAX_ADDR_W = 16;

    typedef struct packed {
        logic [9:0]            x;
        logic [9:0]            y;
        logic [MAX_ADDR_W-1:0] base;
        logic [23:0]           color;
        logic                  visible;
        logic                  flip;
    } sprite_attr_t;

    function automatic logic [COORD_W-1:0] widen(input logic [9:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/sprite_channel.sv
// One sprite channel: stage-1 hit test with ROM row/column registers,
// stage-2 opaque flag from the returned ROM row. Colour rides along.
module sprite_channel
    import sprite_pkg::*;
#(
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32,
    parameter int ADDR_W   = 7
) (
    input  logic                Clk,
    input  logic                Reset,
    input  sprite_attr_t        attr,
    input  logic [9:0]          draw_x,
    input  logic [9:0]          draw_y,
    input  logic [SPRITE_W-1:0] row_data,
    output logic [ADDR_W-1:0]   addr,
    output logic                opaque,
    output logic [23:0]         color
);

    localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam logic [COORD_W-1:0] SPR_W = COORD_W'(SPRITE_W);
    localparam logic [COORD_W-1:0] SPR_H = COORD_W'(SPRITE_H);
    localparam logic [COL_W-1:0]   LAST_COL = COL_W'(SPRITE_W - 1);

    logic [COORD_W-1:0] dx, dy, ax, ay, off_x, off_y;
    logic               hit;
    logic               hit_s1, flip_s1;
    logic [COL_W-1:0]   col_s1, idx;
    logic [23:0]        color_s1;

    always_comb begin
        dx    = widen(draw_x);
        dy    = widen(draw_y);
        ax    = widen(attr.x);
        ay    = widen(attr.y);
        off_x = dx - ax;
        off_y = dy - ay;
        // 11-bit compares: x+SPRITE_W cannot wrap, so right-edge sprites clip
        hit   = attr.visible && (dx >= ax) && (dx < ax + SPR_W)
                             && (dy >= ay) && (dy < ay + SPR_H);
        idx   = flip_s1 ? (LAST_COL - col_s1) : col_s1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hit_s1   <= 1'b0;
            flip_s1  <= 1'b0;
            col_s1   <= '0;
            addr     <= '0;
            color_s1 <= '0;
            opaque   <= 1'b0;
            color    <= '0;
        end else begin
            hit_s1   <= hit;
            flip_s1  <= attr.flip;
            col_s1   <= hit ? COL_W'(off_x) : '0;
            addr     <= hit ? ADDR_W'(attr.base + MAX_ADDR_W'(off_y)) : '0;
            color_s1 <= attr.color;
            opaque   <= hit_s1 && row_data[idx];
            color    <= color_s1;
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// Sprite compositor: double-buffered attributes, NUM_SPRITES channels and a
// text > sprite > background output mux. SPRITE_COLLISION_EN adds collision flags.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_W    = 32,
    parameter int SPRITE_H    = 32,
    parameter int ADDR_W      = 7
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic [9:0]                      DrawX,
    input  logic [9:0]                      DrawY,
    input  logic                            frame_start,
    input  logic                            wr_en,
    input  logic [2:0]                      wr_idx,
    input  logic [9:0]                      wr_x,
    input  logic [9:0]                      wr_y,
    input  logic [ADDR_W-1:0]               wr_base,
    input  logic [23:0]                     wr_color,
    input  logic                            wr_visible,
    input  logic                            wr_flip,
    input  logic [7:0]                      bg_r,
    input  logic [7:0]                      bg_g,
    input  logic [7:0]                      bg_b,
    input  logic                            draw_text,
    input  logic                            text_bit,
    output logic [NUM_SPRITES*ADDR_W-1:0]   sprite_addr,
    input  logic [NUM_SPRITES*SPRITE_W-1:0] sprite_row,
    output logic [7:0]                      VGA_R,
    output logic [7:0]                      VGA_G,
    output logic [7:0]                      VGA_B,
    output logic [NUM_SPRITES-1:0]          collision_mask
);

    sprite_attr_t pending      [NUM_SPRITES];
    sprite_attr_t pending_next [NUM_SPRITES];
    sprite_attr_t active       [NUM_SPRITES];
    sprite_attr_t new_attr;
    logic         wr_ok;

    logic [NUM_SPRITES-1:0] opaque;
    logic [23:0]            ch_color [NUM_SPRITES];

    logic [23:0] bg_d1, bg_d2;
    logic        text_d1, text_d2;
    logic [23:0] pix;
    logic        found;

    always_comb begin
        new_attr.x       = wr_x;
        new_attr.y       = wr_y;
        new_attr.base    = MAX_ADDR_W'(wr_base);
        new_attr.color   = wr_color;
        new_attr.visible = wr_visible;
        new_attr.flip    = wr_flip;
        wr_ok = wr_en && (int'(wr_idx) < NUM_SPRITES);
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            pending_next[i] = pending[i];
            if (wr_ok && (wr_idx == 3'(i)))
                pending_next[i] = new_attr;
        end
    end

    // The commit reads pending_next so a write in the frame_start cycle is included
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                pending[i] <= pending_next[i];
                if (frame_start)
                    active[i] <= pending_next[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_ch
        sprite_channel #(
            .SPRITE_W (SPRITE_W),
            .SPRITE_H (SPRITE_H),
            .ADDR_W   (ADDR_W)
        ) u_ch (
            .Clk      (Clk),
            .Reset    (Reset),
            .attr     (active[g]),
            .draw_x   (DrawX),
            .draw_y   (DrawY),
            .row_data (sprite_row[g*SPRITE_W +: SPRITE_W]),
            .addr     (sprite_addr[g*ADDR_W +: ADDR_W]),
            .opaque   (opaque[g]),
            .color    (ch_color[g])
        );
    end

    always_comb begin
        pix   = bg_d2;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            if (!found && opaque[i]) begin
                pix   = ch_color[i];
                found = 1'b1;
            end
        end
        if (text_d2)
            pix = 24'hFFFFFF;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            bg_d1   <= '0;
            bg_d2   <= '0;
            text_d1 <= 1'b0;
            text_d2 <= 1'b0;
            VGA_R   <= '0;
            VGA_G   <= '0;
            VGA_B   <= '0;
        end else begin
            bg_d1   <= {bg_r, bg_g, bg_b};
            bg_d2   <= bg_d1;
            text_d1 <= draw_text && text_bit;
            text_d2 <= text_d1;
            {VGA_R, VGA_G, VGA_B} <= pix;
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic [NUM_SPRITES-1:0] acc;
    logic [NUM_SPRITES-1:0] contrib;

    always_comb begin
        for (int unsigned i = 0; i < NUM_SPRITES; i++)
            contrib[i] = opaque[i] && |(opaque & ~(NUM_SPRITES'(1) << i));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            acc            <= '0;
            collision_mask <= '0;
        end else if (frame_start) begin
            collision_mask <= acc | contrib;
            acc            <= '0;
        end else begin
            acc <= acc | contrib;
        end
    end
`else
    assign collision_mask = '0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed self-checking bench for sprite_compositor with a constant-row ROM model.
module tb_sprite_compositor;

    localparam int N  = 4;
    localparam int SW = 32;
    localparam int AW = 7;

    logic          Clk, Reset;
    logic [9:0]    DrawX, DrawY;
    logic          frame_start, wr_en;
    logic [2:0]    wr_idx;
    logic [9:0]    wr_x, wr_y;
    logic [AW-1:0] wr_base;
    logic [23:0]   wr_color;
    logic          wr_visible, wr_flip;
    logic [7:0]    bg_r, bg_g, bg_b;
    logic          draw_text, text_bit;
    logic [N*AW-1:0] sprite_addr;
    logic [N*SW-1:0] sprite_row;
    logic [7:0]    VGA_R, VGA_G, VGA_B;
    logic [N-1:0]  collision_mask;
    logic [SW-1:0] rom_pat [N];

    int compared   = 0;
    int mismatched = 0;

    sprite_compositor #(
        .NUM_SPRITES (N),
        .SPRITE_W    (SW),
        .SPRITE_H    (32),
        .ADDR_W      (AW)
    ) dut (
        .Clk (Clk), .Reset (Reset), .DrawX (DrawX), .DrawY (DrawY),
        .frame_start (frame_start), .wr_en (wr_en), .wr_idx (wr_idx),
        .wr_x (wr_x), .wr_y (wr_y), .wr_base (wr_base), .wr_color (wr_color),
        .wr_visible (wr_visible), .wr_flip (wr_flip),
        .bg_r (bg_r), .bg_g (bg_g), .bg_b (bg_b),
        .draw_text (draw_text), .text_bit (text_bit),
        .sprite_addr (sprite_addr), .sprite_row (sprite_row),
        .VGA_R (VGA_R), .VGA_G (VGA_G), .VGA_B (VGA_B),
        .collision_mask (collision_mask)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always_comb begin
        for (int i = 0; i < N; i++)
            sprite_row[i*SW +: SW] = rom_pat[i];
    end

    function automatic logic [23:0] vga();
        return {VGA_R, VGA_G, VGA_B};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic run_px(input logic [9:0] x, input logic [9:0] y);
        DrawX = x;
        DrawY = y;
        tick(); tick(); tick();
    endtask

    task automatic write_attr(input logic [2:0] idx, input logic [9:0] x, input logic [9:0] y,
                              input logic [AW-1:0] base, input logic [23:0] color,
                              input logic vis, input logic flip, input logic commit);
        wr_idx = idx; wr_x = x; wr_y = y; wr_base = base; wr_color = color;
        wr_visible = vis; wr_flip = flip;
        wr_en = 1'b1;
        frame_start = commit;
        tick();
        wr_en = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        logic [23:0] exp;
        Reset = 1'b1;
        tick(); tick();
        compared++;
        if (vga() !== 24'h000000) begin
            $display("FAIL reset_vga: got %h want 000000", vga()); mismatched++;
        end
        compared++;
        if (sprite_addr !== '0) begin
            $display("FAIL reset_addr: got %h want 0", sprite_addr); mismatched++;
        end
        compared++;
        if (collision_mask !== '0) begin
            $display("FAIL reset_mask: got %b want 0", collision_mask); mismatched++;
        end
        Reset = 1'b0;
        {bg_r, bg_g, bg_b} = 24'h102030;
        for (int k = 1; k <= 10; k++) begin
            DrawX = 10'(k - 1);
            tick();
            exp = (k < 3) ? 24'h000000 : 24'h102030;
            compared++;
            if (vga() !== exp) begin
                $display("FAIL bg_pass k=%0d: got %h want %h", k, vga(), exp); mismatched++;
            end
        end
    endtask

    task automatic test_single_sprite();
        write_attr(3'd0, 10'd100, 10'd50, 7'd64, 24'hFF0000, 1'b1, 1'b0, 1'b0);
        pulse_frame();
        DrawX = 10'd100; DrawY = 10'd50;
        tick();
        compared++;
        if (sprite_addr[AW-1:0] !== 7'd64) begin
            $display("FAIL s0_addr: got %0d want 64", sprite_addr[AW-1:0]); mismatched++;
        end
        tick(); tick();
        compared++;
        if (vga() !== 24'hFF0000) begin
            $display("FAIL s0_hit: got %h want ff0000", vga()); mismatched++;
        end
        run_px(10'd131, 10'd50);
        compared++;
        if (vga() !== 24'hFF0000) begin
            $display("FAIL s0_right_edge: got %h want ff0000", vga()); mismatched++;
        end
        run_px(10'd132, 10'd50);
        compared++;
        if (vga() !== 24'h102030) begin
            $display("FAIL s0_past_right: got %h want 102030", vga()); mismatched++;
        end
        compared++;
        if (sprite_addr[AW-1:0] !== 7'd0) begin
            $display("FAIL s0_miss_addr: got %0d want 0", sprite_addr[AW-1:0]); mismatched++;
        end
        run_px(10'd100, 10'd81);
        compared++;
        if (sprite_addr[AW-1:0] !== 7'd95 || vga() !== 24'hFF0000) begin
            $display("FAIL s0_bottom_row: got addr %0d rgb %h want 95 ff0000",
                     sprite_addr[AW-1:0], vga()); mismatched++;
        end
        run_px(10'd100, 10'd82);
        compared++;
        if (vga() !== 24'h102030) begin
            $display("FAIL s0_past_bottom: got %h want 102030", vga()); mismatched++;
        end
    endtask

    task automatic test_priority();
        write_attr(3'd0, 10'd200, 10'd200, 7'd0, 24'hFF0000, 1'b1, 1'b0, 1'b0);
        write_attr(3'd1, 10'd200, 10'd200, 7'd0, 24'h00FF00, 1'b1, 1'b0, 1'b0);
        pulse_frame();
        run_px(10'd210, 10'd205);
        compared++;
        if (vga() !== 24'hFF0000) begin
            $display("FAIL prio_red: got %h want ff0000", vga()); mismatched++;
        end
        write_attr(3'd0, 10'd200, 10'd200, 7'd0, 24'hFF0000, 1'b0, 1'b0, 1'b1);
        run_px(10'd210, 10'd205);
        compared++;
        if (vga() !== 24'h00FF00) begin
            $display("FAIL prio_green: got %h want 00ff00", vga()); mismatched++;
        end
    endtask

    task automatic test_flip();
        write_attr(3'd1, 10'd200, 10'd200, 7'd0, 24'h00FF00, 1'b0, 1'b0, 1'b0);
        write_attr(3'd0, 10'd400, 10'd100, 7'd0, 24'h0000FF, 1'b1, 1'b1, 1'b1);
        rom_pat[0] = 32'h0000_0001;
        run_px(10'd431, 10'd100);
        compared++;
        if (vga() !== 24'h0000FF) begin
            $display("FAIL flip_col31: got %h want 0000ff", vga()); mismatched++;
        end
        run_px(10'd400, 10'd100);
        compared++;
        if (vga() !== 24'h102030) begin
            $display("FAIL flip_col0: got %h want 102030", vga()); mismatched++;
        end
        write_attr(3'd0, 10'd400, 10'd100, 7'd0, 24'h0000FF, 1'b1, 1'b0, 1'b1);
        run_px(10'd400, 10'd100);
        compared++;
        if (vga() !== 24'h0000FF) begin
            $display("FAIL noflip_col0: got %h want 0000ff", vga()); mismatched++;
        end
        run_px(10'd431, 10'd100);
        compared++;
        if (vga() !== 24'h102030) begin
            $display("FAIL noflip_col31: got %h want 102030", vga()); mismatched++;
        end
        rom_pat[0] = '1;
    endtask

    task automatic test_commit();
        write_attr(3'd2, 10'd300, 10'd300, 7'd0, 24'h123456, 1'b1, 1'b0, 1'b0);
        run_px(10'd305, 10'd305);
        compared++;
        if (vga() !== 24'h102030) begin
            $display("FAIL pending_hidden: got %h want 102030", vga()); mismatched++;
        end
        pulse_frame();
        run_px(10'd305, 10'd305);
        compared++;
        if (vga() !== 24'h123456) begin
            $display("FAIL committed: got %h want 123456", vga()); mismatched++;
        end
        write_attr(3'd2, 10'd300, 10'd300, 7'd0, 24'hABCDEF, 1'b1, 1'b0, 1'b1);
        run_px(10'd305, 10'd305);
        compared++;
        if (vga() !== 24'hABCDEF) begin
            $display("FAIL bypass_commit: got %h want abcdef", vga()); mismatched++;
        end
        write_attr(3'd5, 10'd0, 10'd0, 7'd0, 24'h00FFFF, 1'b1, 1'b0, 1'b1);
        run_px(10'd5, 10'd5);
        compared++;
        if (vga() !== 24'h102030) begin
            $display("FAIL bad_idx_ignored: got %h want 102030", vga()); mismatched++;
        end
    endtask

    task automatic test_text();
        draw_text = 1'b1; text_bit = 1'b1;
        run_px(10'd305, 10'd305);
        compared++;
        if (vga() !== 24'hFFFFFF) begin
            $display("FAIL text_over_sprite: got %h want ffffff", vga()); mismatched++;
        end
        text_bit = 1'b0;
        run_px(10'd305, 10'd305);
        compared++;
        if (vga() !== 24'hABCDEF) begin
            $display("FAIL text_bit_low: got %h want abcdef", vga()); mismatched++;
        end
        draw_text = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp;
        DrawY = 10'd305;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) DrawX = 10'(296 + c);
            tick();
            if (c >= 2) begin
                exp = (296 + c - 2 >= 300) ? 24'hABCDEF : 24'h102030;
                compared++;
                if (vga() !== exp) begin
                    $display("FAIL stream x=%0d: got %h want %h", 296 + c - 2, vga(), exp);
                    mismatched++;
                end
            end
        end
    endtask

    task automatic test_collision();
        logic [N-1:0] exp;
        write_attr(3'd0, 10'd500, 10'd400, 7'd0, 24'hFF0000, 1'b1, 1'b0, 1'b0);
        write_attr(3'd1, 10'd531, 10'd400, 7'd0, 24'h00FF00, 1'b1, 1'b0, 1'b1);
        run_px(10'd531, 10'd400);
        compared++;
        if (vga() !== 24'hFF0000) begin
            $display("FAIL overlap_pixel: got %h want ff0000", vga()); mismatched++;
        end
        pulse_frame();
`ifdef SPRITE_COLLISION_EN
        exp = 4'b0011;
`else
        exp = 4'b0000;
`endif
        compared++;
        if (collision_mask !== exp) begin
            $display("FAIL collide_mask: got %b want %b", collision_mask, exp); mismatched++;
        end
        DrawX = 10'd0; DrawY = 10'd0;
        tick(); tick(); tick();
        write_attr(3'd1, 10'd600, 10'd400, 7'd0, 24'h00FF00, 1'b1, 1'b0, 1'b1);
        run_px(10'd531, 10'd400);
        compared++;
        if (vga() !== 24'hFF0000) begin
            $display("FAIL separated_pixel: got %h want ff0000", vga()); mismatched++;
        end
        pulse_frame();
        compared++;
        if (collision_mask !== 4'b0000) begin
            $display("FAIL collide_cleared: got %b want 0000", collision_mask); mismatched++;
        end
    endtask

    initial begin
        Reset = 1'b1; DrawX = '0; DrawY = '0; frame_start = 1'b0; wr_en = 1'b0;
        wr_idx = '0; wr_x = '0; wr_y = '0; wr_base = '0; wr_color = '0;
        wr_visible = 1'b0; wr_flip = 1'b0; bg_r = '0; bg_g = '0; bg_b = '0;
        draw_text = 1'b0; text_bit = 1'b0;
        for (int i = 0; i < N; i++) rom_pat[i] = '1;
        test_reset();
        test_single_sprite();
        test_priority();
        test_flip();
        test_commit();
        test_text();
        test_back_to_back();
        test_collision();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
